// File: rtl/rivyera_reg_responder_pkg.sv
// Shared command codes, FSM state encoding and identification constant for
// the register responder.
package rivyera_reg_responder_pkg;

  localparam logic [7:0]  CMD_WR   = 8'h01;
  localparam logic [7:0]  CMD_RD   = 8'h02;
  localparam logic [7:0]  CMD_RSP  = 8'h03;
  localparam logic [63:0] ID_VALUE = 64'h5245_4731_0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rivyera_reg_bank.sv
// NREG x DATA_W register bank: one write port, combinational read mux,
// register 0 hardwired to the identification constant.
module rivyera_reg_bank #(
  parameter int              REG_W  = 8,
  parameter int              DATA_W = 64,
  parameter int              NREG   = 16,
  parameter logic [DATA_W-1:0] ID   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [REG_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [REG_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [NREG*DATA_W-1:0] reg_q
);

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign reg_q[0 +: DATA_W] = ID;
    end else begin : g_rw
      logic [DATA_W-1:0] r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r <= '0;
        end else if (wr_en && (wr_addr == REG_W'(i))) begin
          r <= wr_data;
        end
      end
      assign reg_q[i*DATA_W +: DATA_W] = r;
    end
  end

  // Addresses at or beyond NREG match no entry and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == REG_W'(i)) rd_data = reg_q[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/rivyera_reg_responder.sv
// Register-file responder: pops write/read requests from the API input FIFO,
// updates the local bank, and answers reads on the API output port.
module rivyera_reg_responder
  import rivyera_reg_responder_pkg::*;
#(
  parameter int SLOT_W = 5,
  parameter int FPGA_W = 4,
  parameter int REG_W  = 8,
  parameter int CMD_W  = 8,
  parameter int DATA_W = 64,
  parameter int NREG   = 16
) (
  input  logic                   api_clk_in,
  input  logic                   api_rst_in,
  output logic                   api_i_clk_out,
  input  logic [SLOT_W-1:0]      api_i_src_slot_in,
  input  logic [FPGA_W-1:0]      api_i_src_fpga_in,
  input  logic [REG_W-1:0]       api_i_src_reg_in,
  input  logic [CMD_W-1:0]       api_i_src_cmd_in,
  input  logic [REG_W-1:0]       api_i_tgt_reg_in,
  input  logic [CMD_W-1:0]       api_i_tgt_cmd_in,
  input  logic [DATA_W-1:0]      api_i_data_in,
  input  logic                   api_i_empty_in,
  input  logic                   api_i_am_empty_in,
  output logic                   api_i_rd_en_out,
  output logic                   api_o_clk_out,
  input  logic                   api_o_rfd_in,
  output logic [SLOT_W-1:0]      api_o_tgt_slot_out,
  output logic [FPGA_W-1:0]      api_o_tgt_fpga_out,
  output logic [REG_W-1:0]       api_o_tgt_reg_out,
  output logic [CMD_W-1:0]       api_o_tgt_cmd_out,
  output logic [REG_W-1:0]       api_o_src_reg_out,
  output logic [CMD_W-1:0]       api_o_src_cmd_out,
  output logic [DATA_W-1:0]      api_o_data_out,
  output logic                   api_o_wr_en_out,
  output logic [NREG*DATA_W-1:0] reg_q_out,
  output logic [15:0]            err_cnt_out
);

  // Handshakes: input side is FWFT, a word is consumed on any edge where
  // empty=0 and rd_en=1; output side pushes on any edge where wr_en=1, which
  // is only raised while rfd=1, and the fields stay put until that edge.
  state_t state_q, state_d;

  logic [SLOT_W-1:0] h_src_slot;
  logic [FPGA_W-1:0] h_src_fpga;
  logic [REG_W-1:0]  h_src_reg;
  logic [CMD_W-1:0]  h_src_cmd;
  logic [REG_W-1:0]  h_tgt_reg;
  logic [CMD_W-1:0]  h_tgt_cmd;
  logic [DATA_W-1:0] h_data;

  logic              bank_we;
  logic              err_inc;
  logic              rsp_load;
  logic [DATA_W-1:0] rd_data;
  logic              is_wr, is_rd, wr_ok;
  logic              unused_am_empty;

  assign unused_am_empty = api_i_am_empty_in;
  assign api_i_clk_out   = api_clk_in;
  assign api_o_clk_out   = api_clk_in;

  assign api_i_rd_en_out = (state_q == ST_IDLE) & ~api_i_empty_in & ~api_rst_in;
  assign api_o_wr_en_out = (state_q == ST_RESP) & api_o_rfd_in;

  assign is_wr = (h_tgt_cmd == CMD_W'(CMD_WR));
  assign is_rd = (h_tgt_cmd == CMD_W'(CMD_RD));
  assign wr_ok = (h_tgt_reg != '0) && (h_tgt_reg < REG_W'(NREG));

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bank_we  = 1'b0;
    err_inc  = 1'b0;
    rsp_load = 1'b0;
    case (state_q)
      ST_IDLE: if (api_i_rd_en_out) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (is_wr) begin
          bank_we = wr_ok;
          err_inc = ~wr_ok;
        end else if (is_rd) begin
          rsp_load = 1'b1;
          state_d  = ST_RESP;
        end else begin
          err_inc = 1'b1;
        end
      end
      ST_RESP: if (api_o_rfd_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) begin
      h_src_slot <= '0;
      h_src_fpga <= '0;
      h_src_reg  <= '0;
      h_src_cmd  <= '0;
      h_tgt_reg  <= '0;
      h_tgt_cmd  <= '0;
      h_data     <= '0;
    end else if (api_i_rd_en_out) begin
      h_src_slot <= api_i_src_slot_in;
      h_src_fpga <= api_i_src_fpga_in;
      h_src_reg  <= api_i_src_reg_in;
      h_src_cmd  <= api_i_src_cmd_in;
      h_tgt_reg  <= api_i_tgt_reg_in;
      h_tgt_cmd  <= api_i_tgt_cmd_in;
      h_data     <= api_i_data_in;
    end
  end

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) begin
      api_o_tgt_slot_out <= '0;
      api_o_tgt_fpga_out <= '0;
      api_o_tgt_reg_out  <= '0;
      api_o_tgt_cmd_out  <= '0;
      api_o_src_reg_out  <= '0;
      api_o_src_cmd_out  <= '0;
      api_o_data_out     <= '0;
    end else if (rsp_load) begin
      api_o_tgt_slot_out <= h_src_slot;
      api_o_tgt_fpga_out <= h_src_fpga;
      api_o_tgt_reg_out  <= h_src_reg;
      api_o_tgt_cmd_out  <= CMD_W'(CMD_RSP);
      api_o_src_reg_out  <= h_tgt_reg;
      api_o_src_cmd_out  <= h_src_cmd;
      api_o_data_out     <= rd_data;
    end
  end

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in)                           err_cnt_out <= '0;
    else if (err_inc && (err_cnt_out != '1))  err_cnt_out <= err_cnt_out + 16'd1;
  end

  rivyera_reg_bank #(
    .REG_W  (REG_W),
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ID     (DATA_W'(ID_VALUE))
  ) u_bank (
    .clk     (api_clk_in),
    .rst     (api_rst_in),
    .wr_en   (bank_we),
    .wr_addr (h_tgt_reg),
    .wr_data (h_data),
    .rd_addr (h_tgt_reg),
    .rd_data (rd_data),
    .reg_q   (reg_q_out)
  );

endmodule

// File: doc/rivyera_reg_responder.md
Name: rivyera_reg_responder

Overview:
- Register-file responder on the SciEngines API user side; it is the other end of the host/peer initiator that drives the API input FIFO.
- Pops request words from the API input FIFO and decodes each as a register write or a register read.
- Writes go to a local register bank. Reads return a response word on the API output port, addressed back to the requester.
- Instantiated inside the user main module in place of ad-hoc FIFO handling.

Parameters:
SLOT_W, 5, width of slot address fields
FPGA_W, 4, width of FPGA address fields
REG_W, 8, width of register address fields
CMD_W, 8, width of command fields
DATA_W, 64, data word width
NREG, 16, number of implemented registers (addresses 0..NREG-1)
CMD_WR, 8'h01, write request command
CMD_RD, 8'h02, read request command
CMD_RSP, 8'h03, read response command
ID_VALUE, 64'h5245_4731_0000_0001, constant returned by register 0

Ports:
api_clk_in  in  1  sole clock
api_rst_in  in  1  asynchronous, active-high reset
api_i_clk_out  out  1  input FIFO read clock; equals api_clk_in
api_i_src_slot_in  in  SLOT_W  requester slot
api_i_src_fpga_in  in  FPGA_W  requester FPGA
api_i_src_reg_in  in  REG_W  requester reply register
api_i_src_cmd_in  in  CMD_W  requester command tag (echoed)
api_i_tgt_reg_in  in  REG_W  local register address
api_i_tgt_cmd_in  in  CMD_W  request command
api_i_data_in  in  DATA_W  write data
api_i_empty_in  in  1  input FIFO empty
api_i_am_empty_in  in  1  almost empty (ignored)
api_i_rd_en_out  out  1  pop input FIFO
api_o_clk_out  out  1  output FIFO write clock; equals api_clk_in
api_o_rfd_in  in  1  output ready for data
api_o_tgt_slot_out  out  SLOT_W  response target slot
api_o_tgt_fpga_out  out  FPGA_W  response target FPGA
api_o_tgt_reg_out  out  REG_W  response target register
api_o_tgt_cmd_out  out  CMD_W  response command
api_o_src_reg_out  out  REG_W  register that was read
api_o_src_cmd_out  out  CMD_W  echoed requester command tag
api_o_data_out  out  DATA_W  read data
api_o_wr_en_out  out  1  push output word
reg_q_out  out  NREG*DATA_W  flat register bank, exported to the main logic
err_cnt_out  out  16  count of dropped requests, saturating

Behaviour:
- Input FIFO is first-word-fall-through: the head word is valid whenever api_i_empty_in=0, and api_i_rd_en_out=1 pops it at the clock edge.
- States:
  - IDLE: api_i_rd_en_out = (state==IDLE) & ~api_i_empty_in, combinational. On a pop, all head fields are latched into holding registers; next state is EXEC.
  - EXEC:
    - CMD_WR with 1 <= tgt_reg < NREG: reg[tgt_reg] <= data; next IDLE.
    - CMD_WR to reg 0 or to an address >= NREG: dropped, err_cnt+1, next IDLE.
    - CMD_RD: response fields are registered; next RESP. Read data is ID_VALUE for reg 0, reg[tgt_reg] for 1..NREG-1, and 0 for an address >= NREG (not an error).
    - Any other command: dropped, err_cnt+1, next IDLE.
  - RESP: api_o_wr_en_out = (state==RESP) & api_o_rfd_in, combinational. Leave RESP to IDLE on the cycle it is 1; otherwise hold all api_o_* fields stable indefinitely.
- Response fields:
  - tgt_slot/tgt_fpga/tgt_reg = latched src_slot/src_fpga/src_reg.
  - tgt_cmd = CMD_RSP.
  - src_reg = latched tgt_reg.
  - src_cmd = latched src_cmd.
- Throughput: write takes 2 cycles per word. Read takes 3 cycles per word when rfd is continuously 1.
- Ordering: a new pop cannot occur while in EXEC or RESP, so responses leave in request order.
- A write in EXEC takes effect before any later read is decoded (read-after-write is coherent).
- err_cnt saturates at 16'hFFFF.
- Reset, including mid-operation: state=IDLE, all registers 0, err_cnt 0, api_o_* fields 0, wr_en/rd_en 0. A request held in RESP is discarded and never re-sent.
- api_o_rfd_in going 0 in the cycle of entering RESP only delays the push; nothing is lost.

Decomposition:
- Shared package/header: command codes (CMD_WR, CMD_RD, CMD_RSP), the state encoding, and ID_VALUE.
- Field widths come from the existing API constant definitions at instantiation.
- One natural sub-module: rivyera_reg_bank (NREG x DATA_W storage, single write port, async read mux, reg 0 hardwired to ID_VALUE).

Test Plan:
- Write reg 3 = 64'hDEAD_BEEF_0000_0003, then read reg 3 from slot 2/fpga 1/src_reg 7 -> one push with tgt_slot 2, tgt_fpga 1, tgt_reg 7, tgt_cmd 8'h03, src_reg 3, data 64'hDEAD_BEEF_0000_0003.
- Read reg 0 -> data = ID_VALUE. Write reg 0 -> err_cnt 1, register unchanged. Read reg 20 (NREG=16) -> data 0, err_cnt unchanged.
- Read with api_o_rfd_in held 0 for 10 cycles -> wr_en stays 0, fields stable, and no further pops occur. After rfd=1 -> exactly one push.
- Back-to-back FIFO of 4 writes then 4 reads, rfd=1 -> rd_en pulses in 8-request order, 4 pushes in order, 20 cycles total.
- Command 8'h7F -> popped and dropped, err_cnt 1, no push.
- Assert api_rst_in asynchronously while in RESP -> all outputs 0 immediately, no push after release, and the next request is handled normally.
